// File: rtl/ahb_dma_prio_arb_if.sv
// Request/grant bundle between the DMA channel request lines and the channel arbiter.
// The slave modport is the arbiter; the master modport is the DMA engine and channel side.
interface ahb_dma_prio_arb_if #(
   parameter int CH_NUM = 19,
   parameter int PRI_W  = 2,
   localparam int CH_W  = $clog2(CH_NUM)
);
   logic [CH_NUM-1:0]       req;
   logic [CH_NUM*PRI_W-1:0] pri;
   logic                    mode;
   logic                    advance;
   logic                    lock;
   logic [CH_W-1:0]         gnt;
   logic                    gnt_valid;

   modport slave (
      input  req,
      input  pri,
      input  mode,
      input  advance,
      input  lock,
      output gnt,
      output gnt_valid
   );

   modport master (
      output req,
      output pri,
      output mode,
      output advance,
      output lock,
      input  gnt,
      input  gnt_valid
   );
endinterface

// File: rtl/ahb_dma_prio_arb.sv
// DMA channel arbiter: round-robin or priority with round-robin among equal levels.
// Supports grant-valid, auto-release on a dropped request, and a lock that freezes the grant.
module ahb_dma_prio_arb #(
   parameter int CH_NUM = 19,
   parameter int PRI_W  = 2,
   localparam int CH_W  = $clog2(CH_NUM)
) (
   input logic                clk,
   input logic                rst,
   ahb_dma_prio_arb_if.slave  bus
);
   localparam logic [CH_W:0] LP_CH_NUM = (CH_W+1)'(CH_NUM);

   logic [CH_W-1:0]   r_gnt;
   logic              r_gnt_valid;

   logic [PRI_W-1:0]  w_max_pri;
   logic [CH_NUM-1:0] w_elig;
   logic [CH_W:0]     w_sum;
   logic [CH_W-1:0]   w_idx;
   logic              w_found;
   logic [CH_W-1:0]   w_winner;
   logic              w_event;
   logic [CH_W-1:0]   w_gnt_nxt;
   logic              w_valid_nxt;

   // Highest priority level among requesters, then the set of channels contending at it
   always_comb begin
      w_max_pri = '0;
      w_elig    = '0;
      for (int k = 0; k < CH_NUM; k++) begin
         if (bus.req[k] && (bus.pri[k*PRI_W +: PRI_W] > w_max_pri)) begin
            w_max_pri = bus.pri[k*PRI_W +: PRI_W];
         end else begin
            w_max_pri = w_max_pri;
         end
      end
      for (int k = 0; k < CH_NUM; k++) begin
         w_elig[k] = bus.req[k] && (!bus.mode || (bus.pri[k*PRI_W +: PRI_W] == w_max_pri));
      end
   end

   // Circular scan from gnt+1 (mod CH_NUM) ending at gnt, so the holder is last in line
   always_comb begin
      w_found  = 1'b0;
      w_winner = r_gnt;
      w_sum    = '0;
      w_idx    = '0;
      for (int i = 1; i <= CH_NUM; i++) begin
         w_sum = {1'b0, r_gnt} + (CH_W+1)'(i);
         if (w_sum >= LP_CH_NUM) begin
            w_idx = CH_W'(w_sum - LP_CH_NUM);
         end else begin
            w_idx = CH_W'(w_sum);
         end
         if (!w_found && w_elig[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end else begin
            w_found  = w_found;
         end
      end
   end

   // Arbitration event and next grant; an empty request set keeps gnt as the rotation pointer
   always_comb begin
      w_event     = !bus.lock && (bus.advance || !r_gnt_valid || !bus.req[r_gnt]);
      w_gnt_nxt   = r_gnt;
      w_valid_nxt = r_gnt_valid;
      if (w_event) begin
         if (|bus.req) begin
            w_gnt_nxt   = w_winner;
            w_valid_nxt = 1'b1;
         end else begin
            w_valid_nxt = 1'b0;
         end
      end else begin
         w_valid_nxt = r_gnt_valid;
      end
   end

   // Grant state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_gnt       <= '0;
         r_gnt_valid <= 1'b0;
      end else begin
         r_gnt       <= w_gnt_nxt;
         r_gnt_valid <= w_valid_nxt;
      end
   end

   assign bus.gnt       = r_gnt;
   assign bus.gnt_valid = r_gnt_valid;
endmodule

// File: tb/tb_ahb_dma_prio_arb.sv
// Directed bench for ahb_dma_prio_arb with a scoreboard queue of expected grants.
module tb_ahb_dma_prio_arb;
   localparam int CH_NUM = 19;
   localparam int PRI_W  = 2;

   typedef struct {
      string    tag;
      logic [4:0] g;
      logic     v;
   } exp_t;

   logic clk;
   logic rst;
   exp_t sb[$];
   int   vectors;
   int   miscompares;

   ahb_dma_prio_arb_if #(.CH_NUM(CH_NUM), .PRI_W(PRI_W)) bus ();

   ahb_dma_prio_arb #(.CH_NUM(CH_NUM), .PRI_W(PRI_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic expect_push(input string tag, input int g, input bit v);
      exp_t e;
      e.tag = tag;
      e.g   = 5'(g);
      e.v   = v;
      sb.push_back(e);
   endtask

   task automatic compare_pop();
      exp_t e;
      e = sb.pop_front();
      vectors++;
      assert ({bus.gnt, bus.gnt_valid} === {e.g, e.v}) else begin
         miscompares++;
         $error("FAIL %s: gnt=%0d gnt_valid=%0b, expected gnt=%0d gnt_valid=%0b",
                e.tag, bus.gnt, bus.gnt_valid, e.g, e.v);
      end
   endtask

   task automatic check_now(input string tag, input int g, input bit v);
      expect_push(tag, g, v);
      compare_pop();
   endtask

   task automatic tick_chk(input string tag, input int g, input bit v);
      expect_push(tag, g, v);
      @(posedge clk);
      #1;
      compare_pop();
   endtask

   task automatic set_all_pri(input int val);
      for (int k = 0; k < CH_NUM; k++) bus.pri[k*PRI_W +: PRI_W] = PRI_W'(val);
   endtask

   task automatic set_pri(input int ch, input int val);
      bus.pri[ch*PRI_W +: PRI_W] = PRI_W'(val);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b0;
      bus.req     = '0;
      bus.pri     = '0;
      bus.mode    = 1'b0;
      bus.advance = 1'b0;
      bus.lock    = 1'b0;
      #12;
      check_now("reset", 0, 1'b0);
      rst = 1'b1;

      for (int s = 0; s < 5; s++) tick_chk("idle", 0, 1'b0);
      bus.req = 19'(1) << 5;
      tick_chk("first_grant", 5, 1'b1);

      // round-robin sweep across the wrap
      bus.req     = '1;
      bus.advance = 1'b1;
      for (int s = 6; s <= 21; s++) tick_chk("rr_rotate", s % CH_NUM, 1'b1);

      // priority: channel 7 dominates
      bus.mode = 1'b1;
      set_all_pri(1);
      set_pri(7, 3);
      bus.req = '0;
      bus.req[2] = 1'b1; bus.req[7] = 1'b1; bus.req[12] = 1'b1;
      tick_chk("pri_win", 7, 1'b1);
      tick_chk("pri_hold_adv", 7, 1'b1);
      tick_chk("pri_hold_adv2", 7, 1'b1);
      bus.advance = 1'b0;
      bus.req[7]  = 1'b0;
      tick_chk("pri_autorel", 12, 1'b1);
      bus.advance = 1'b1;
      tick_chk("pri_wrap", 2, 1'b1);
      bus.advance = 1'b0;
      tick_chk("no_event_hold", 2, 1'b1);

      // equal-priority fairness
      set_all_pri(2);
      bus.req = '0;
      bus.req[3] = 1'b1; bus.req[4] = 1'b1; bus.req[9] = 1'b1;
      bus.advance = 1'b1;
      tick_chk("fair_3", 3, 1'b1);
      tick_chk("fair_4", 4, 1'b1);
      tick_chk("fair_9", 9, 1'b1);
      tick_chk("fair_3b", 3, 1'b1);
      tick_chk("fair_4b", 4, 1'b1);

      // lock freezes grant despite advance and dropped request
      bus.lock   = 1'b1;
      bus.req[4] = 1'b0;
      tick_chk("lock_hold", 4, 1'b1);
      tick_chk("lock_hold2", 4, 1'b1);
      bus.lock    = 1'b0;
      bus.advance = 1'b0;
      tick_chk("lock_release", 9, 1'b1);
      bus.lock    = 1'b1;
      bus.advance = 1'b1;
      tick_chk("lock_adv", 9, 1'b1);
      bus.lock    = 1'b0;
      bus.advance = 1'b0;
      tick_chk("adv_discarded", 9, 1'b1);

      // empty request set keeps pointer, lone requester re-granted
      bus.req = '0;
      tick_chk("idle_drop", 9, 1'b0);
      bus.advance = 1'b1;
      tick_chk("idle_adv", 9, 1'b0);
      bus.advance = 1'b0;
      bus.req[9]  = 1'b1;
      tick_chk("lone_regrant", 9, 1'b1);

      // mode 0 ignores priority, mode 1 honours it
      set_all_pri(0);
      set_pri(9, 3);
      bus.req[3] = 1'b1; bus.req[4] = 1'b1;
      bus.mode    = 1'b0;
      bus.advance = 1'b1;
      tick_chk("mode0_ignores_pri", 3, 1'b1);
      bus.mode = 1'b1;
      tick_chk("mode1_pri", 9, 1'b1);
      bus.advance = 1'b0;

      // asynchronous reset mid-grant
      bus.mode = 1'b0;
      bus.req  = '0;
      bus.req[11] = 1'b1;
      tick_chk("pre_reset_grant", 11, 1'b1);
      tick_chk("pre_reset_hold", 11, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      check_now("async_reset", 0, 1'b0);
      bus.req = '1;
      tick_chk("in_reset", 0, 1'b0);
      rst = 1'b1;
      tick_chk("post_reset_grant", 1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/ahb_dma_prio_arb.md
# ahb_dma_prio_arb

Parametrised channel arbiter for the AHB DMA engine. It replaces the fixed round-robin channel arbiter with a selectable mode: pure round-robin, or per-channel programmable priority with round-robin among equal levels. It also adds a grant-valid flag, automatic release when the granted channel drops its request, and a bus-lock hold. It sits between the per-channel request lines and the DMA master engine, which consumes `gnt`/`gnt_valid` and pulses `advance` at transfer boundaries.

## Interface
- `CH_NUM`, 19: number of DMA channels; legal range 2..32.
- `PRI_W`, 2: priority field width per channel (2^PRI_W levels; larger value = higher priority).
- `CH_W`, `$clog2(CH_NUM)`: grant index width; derived, not overridden.

Ports (reset `rst` is asynchronous, active-low; clock is `clk`):
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  CH_NUM  per-channel request, level-sensitive.
- `pri`  in  CH_NUM*PRI_W  channel k priority at bits [k*PRI_W +: PRI_W]; static between arbitration events.
- `mode`  in  1  0 = round-robin (ignore `pri`), 1 = priority + round-robin within level.
- `advance`  in  1  single-cycle pulse: current transfer segment done, re-arbitrate.
- `lock`  in  1  hold current grant; suppresses all re-arbitration.
- `gnt`  out  CH_W  granted channel index, registered.
- `gnt_valid`  out  1  `gnt` is a live grant, registered.

## Operation
- Registered state: `gnt`, `gnt_valid`. Reset values: `gnt` = 0, `gnt_valid` = 0.
- Arbitration event (evaluated every cycle): `!lock && (advance || !gnt_valid || !req[gnt])`.
- With `lock` = 1, `gnt`/`gnt_valid` hold regardless of `advance` or `req`, including a dropped `req[gnt]`.
- On an event with `req` != 0:
  - `gnt_valid` <= 1.
  - `gnt` <= winner.
- On an event with `req` = 0:
  - `gnt_valid` <= 0.
  - `gnt` holds its value, which keeps the rotation pointer.
- Winner search order: circular scan starting at `gnt`+1, wrapping from CH_NUM-1 to 0, ending at `gnt` itself.
  - The current holder is therefore last in line.
  - A lone requester is re-granted.
- mode 0 winner: first requesting channel in the search order.
- mode 1 winner:
  - L = maximum `pri` among requesting channels.
  - Winner = first requesting channel in the search order whose `pri` == L.
- Indices at or above CH_NUM never appear on `gnt`. The wrap is modulo CH_NUM, not 2^CH_W.
- `mode` may change at any time and takes effect at the next event. No state is flushed.
- Auto-release (`!req[gnt]` while `gnt_valid`) behaves as an event. The same search order applies, starting at `gnt`+1.
- Priority arithmetic is unsigned compare on PRI_W-bit fields. Equal priorities fall back to rotation.

## Timing
- All outputs change only on `clk` rising edge, or asynchronously to reset values when `rst` = 0.
- Latency from idle:
  - `req` asserted in cycle N produces `gnt_valid` = 1 and a valid `gnt` after edge N+1.
  - That is one-cycle latency.
- `advance` in cycle N: the new `gnt` is visible after edge N+1. No idle cycle appears between back-to-back grants.
- `advance` and `lock` asserted together: `lock` wins and `advance` is discarded, not remembered.
- `advance` while `gnt_valid` = 0 is harmless. Behaviour is identical to an idle event.
- Reset mid-grant:
  - `gnt` = 0, `gnt_valid` = 0 immediately.
  - First post-reset grant searches from channel 1 (pointer 0).
- Deassertion of `req[gnt]` in cycle N: `gnt` moves, or `gnt_valid` drops, after edge N+1.

## Test plan
- Reset/idle: `rst` low then high, `req` = 0 for 5 cycles -> `gnt` = 0, `gnt_valid` = 0 throughout. Then `req` = 1<<5 -> next edge `gnt` = 5, `gnt_valid` = 1.
- Round-robin rotation: `mode` = 0, `req` = all ones, `advance` every cycle -> `gnt` steps 1,2,…,18,0,1 (CH_NUM = 19). Wrap skips indices 19..31.
- Priority: `mode` = 1, `req` = channels 2,7,12, `pri`[7] = 3, others 1 -> `gnt` = 7 and stays 7 on every `advance`. Drop `req`[7] -> `gnt` goes to 12, then 2 on the next `advance`.
- Equal-priority fairness: `mode` = 1, channels 3,4,9 all `pri` = 2 and requesting -> `gnt` cycles 3,4,9,3 on successive `advance`.
- Lock: `gnt` = 4, `lock` = 1, pulse `advance` and drop `req`[4] -> `gnt` stays 4 and `gnt_valid` stays 1. Release `lock` -> next edge re-arbitrates.
- Reset mid-operation: assert `rst` low asynchronously while `gnt` = 11 -> outputs go to 0/0 before the next edge. After release with `req` = all ones, first `gnt` = 1.
